// File: rtl/blink_pkg.sv
`default_nettype none
// ============================================================================
// Module  : blink_pkg
// Purpose : Shared types and board-level timing defaults for the LED blinker's
//           button conditioning path.
// Contents: btn_state_t - debounce FSM state encoding
//           CLK_HZ, DEBOUNCE_MS, LONG_MS - default board timing constants
// Revision: 1.0 - initial release
// ============================================================================
package blink_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 20;
  localparam int LONG_MS     = 1000;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEB_PRESS   = 3'd1,
    ST_HELD        = 3'd2,
    ST_LONG_HELD   = 3'd3,
    ST_DEB_RELEASE = 3'd4
  } btn_state_t;

endpackage
`default_nettype wire

// File: rtl/btn_sync.sv
`default_nettype none
// ============================================================================
// Module  : btn_sync
// Purpose : Multi-flop synchroniser for a single asynchronous board input.
// Ports   : CLK - destination clock
//           RST - asynchronous active-high reset, clears every stage
//           D   - asynchronous input
//           Q   - synchronised output (last stage)
// Revision: 1.0 - initial release
// ============================================================================
module btn_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic [STAGES-1:0] r_sync;

  // Bit 0 is the metastability-catching flop; data shifts toward the MSB.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], D};
    end
  end

  assign Q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module  : button_debounce
// Purpose : Synchronises and debounces one raw push-button and classifies
//           each press as short (pulse on release) or long (pulse while held).
// Ports   : CLK        - system clock, rising edge
//           RST        - asynchronous active-high reset
//           BTN        - raw, bouncy, asynchronous button input
//           BTN_LEVEL  - debounced button level (registered)
//           PRESS      - one-cycle pulse on release of a press that never
//                        reached the long threshold (registered)
//           LONG_PRESS - one-cycle pulse when a hold reaches LONG_CYCLES
//                        (registered)
// Revision: 1.0 - initial release
// ============================================================================
module button_debounce
  import blink_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS,
  parameter int LONG_CYCLES     = (CLK_HZ / 1000) * LONG_MS
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic BTN_LEVEL,
  output logic PRESS,
  output logic LONG_PRESS
);

  localparam int c_DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int c_HOLD_W = $clog2(LONG_CYCLES);

  localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_DEB_W-1:0]  c_DEB_ONE   = c_DEB_W'(1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);

  logic                w_btn_s;
  btn_state_t          r_state;
  logic [c_DEB_W-1:0]  r_deb_cnt;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic                r_long_flag;
  logic                r_level;
  logic                r_press;
  logic                r_long;

  btn_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (BTN),
    .Q   (w_btn_s)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_deb_cnt   <= '0;
      r_hold_cnt  <= '0;
      r_long_flag <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_press <= 1'b0;
      r_long  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_btn_s) begin
            r_state   <= ST_DEB_PRESS;
            r_deb_cnt <= '0;
          end
        end

        ST_DEB_PRESS: begin
          if (!w_btn_s) begin
            r_state <= ST_IDLE;
          end else if (r_deb_cnt == c_DEB_LAST) begin
            r_state     <= ST_HELD;
            r_level     <= 1'b1;
            r_hold_cnt  <= '0;
            r_long_flag <= 1'b0;
          end else begin
            r_deb_cnt <= r_deb_cnt + c_DEB_ONE;
          end
        end

        // A release seen on the same cycle as the long threshold wins, so a
        // press cut short at the boundary is reported as short.
        ST_HELD: begin
          if (!w_btn_s) begin
            r_state   <= ST_DEB_RELEASE;
            r_deb_cnt <= '0;
          end else if (r_hold_cnt == c_HOLD_LAST) begin
            r_state     <= ST_LONG_HELD;
            r_long      <= 1'b1;
            r_long_flag <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
          end
        end

        ST_LONG_HELD: begin
          if (!w_btn_s) begin
            r_state   <= ST_DEB_RELEASE;
            r_deb_cnt <= '0;
          end
        end

        // hold_cnt is left untouched here so a rejected release bounce
        // resumes the hold timer where it stopped.
        ST_DEB_RELEASE: begin
          if (w_btn_s) begin
            r_state <= r_long_flag ? ST_LONG_HELD : ST_HELD;
          end else if (r_deb_cnt == c_DEB_LAST) begin
            r_state <= ST_IDLE;
            r_level <= 1'b0;
            r_press <= ~r_long_flag;
          end else begin
            r_deb_cnt <= r_deb_cnt + c_DEB_ONE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign BTN_LEVEL  = r_level;
  assign PRESS      = r_press;
  assign LONG_PRESS = r_long;

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_debounce
// Purpose : Self-checking bench for button_debounce. A run-length reference
//           model predicts BTN_LEVEL, PRESS and LONG_PRESS every cycle;
//           directed scenarios add fixed timing checks, followed by random
//           press/release/reset traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_button_debounce;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic btn_level;
  logic press;
  logic long_press;

  int n_pass  = 0;
  int n_total = 0;
  int n_press_seen = 0;
  int n_long_seen  = 0;
  int n_level_seen = 0;
  int p0, l0, v0;

  always #10 clk = ~clk;

  button_debounce #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .BTN        (btn),
    .BTN_LEVEL  (btn_level),
    .PRESS      (press),
    .LONG_PRESS (long_press)
  );

  // Reference model: the level flips once the synchronised button has
  // disagreed with it for DEB+1 consecutive samples; a hold sample counts
  // when the button was seen high on this and the previous sample while the
  // level is high, and the LONG-th such sample fires the long pulse once.
  logic [SYNC-1:0] m_pipe;
  logic m_prev, m_level, m_press, m_long, m_long_done;
  int   m_run, m_hold;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pipe      <= '0;
      m_prev      <= 1'b0;
      m_level     <= 1'b0;
      m_press     <= 1'b0;
      m_long      <= 1'b0;
      m_long_done <= 1'b0;
      m_run       <= 0;
      m_hold      <= 0;
    end else begin : model_step
      logic seen, lvl, done, p, l;
      int   run, hold;
      seen = m_pipe[SYNC-1];
      run  = (seen != m_level) ? m_run + 1 : 0;
      hold = m_hold;
      lvl  = m_level;
      done = m_long_done;
      p    = 1'b0;
      l    = 1'b0;
      if (run == DEB + 1) begin
        if (m_level) begin
          lvl = 1'b0;
          p   = ~m_long_done;
        end else begin
          lvl  = 1'b1;
          hold = 0;
          done = 1'b0;
        end
        run = 0;
      end else if (m_level && seen && m_prev) begin
        hold = hold + 1;
        if (hold == LONG && !done) begin
          l    = 1'b1;
          done = 1'b1;
        end
      end
      m_pipe      <= {m_pipe[SYNC-2:0], btn};
      m_prev      <= seen;
      m_run       <= run;
      m_hold      <= hold;
      m_level     <= lvl;
      m_long_done <= done;
      m_press     <= p;
      m_long      <= l;
    end
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs == exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance n cycles, comparing every output against the model mid-cycle.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("model_level", btn_level, m_level);
      chk("model_press", press, m_press);
      chk("model_long", long_press, m_long);
      if (press)      n_press_seen++;
      if (long_press) n_long_seen++;
      if (btn_level)  n_level_seen++;
    end
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_level", btn_level, 1'b0);
    chk("reset_press", press, 1'b0);
    chk("reset_long", long_press, 1'b0);
    rst = 1'b0;
    cyc(3);

    // Clean short press: 10 cycles high.
    p0 = n_press_seen; l0 = n_long_seen;
    btn = 1'b1;
    cyc(6);
    chk("short_level_early", btn_level, 1'b0);
    cyc(1);
    chk("short_level_rise", btn_level, 1'b1);
    cyc(3);
    btn = 1'b0;
    cyc(6);
    chk("short_press_early", press, 1'b0);
    chk("short_level_hold", btn_level, 1'b1);
    cyc(1);
    chk("short_press_pulse", press, 1'b1);
    chk("short_level_fall", btn_level, 1'b0);
    cyc(4);
    chk_int("short_press_count", n_press_seen - p0, 1);
    chk_int("short_long_count", n_long_seen - l0, 0);

    // Bounce rejection: 1,0,1,0 with 2-cycle widths.
    p0 = n_press_seen; l0 = n_long_seen; v0 = n_level_seen;
    btn = 1'b1; cyc(2);
    btn = 1'b0; cyc(2);
    btn = 1'b1; cyc(2);
    btn = 1'b0; cyc(12);
    chk_int("bounce_level_cycles", n_level_seen - v0, 0);
    chk_int("bounce_press_count", n_press_seen - p0, 0);
    chk_int("bounce_long_count", n_long_seen - l0, 0);

    // Long press: 40 cycles high.
    p0 = n_press_seen; l0 = n_long_seen;
    btn = 1'b1;
    cyc(26);
    chk("long_early", long_press, 1'b0);
    cyc(1);
    chk("long_pulse", long_press, 1'b1);
    chk("long_level", btn_level, 1'b1);
    cyc(1);
    chk("long_one_cycle", long_press, 1'b0);
    cyc(12);
    btn = 1'b0;
    cyc(6);
    chk("long_level_held", btn_level, 1'b1);
    cyc(1);
    chk("long_level_fall", btn_level, 1'b0);
    chk("long_no_press", press, 1'b0);
    cyc(3);
    chk_int("long_press_count", n_press_seen - p0, 0);
    chk_int("long_long_count", n_long_seen - l0, 1);

    // Release bounce in HELD: hold timer resumes, long pulse 3 edges later.
    p0 = n_press_seen;
    btn = 1'b1; cyc(10);
    btn = 1'b0; cyc(2);
    btn = 1'b1;
    cyc(17);
    chk("relb_long_early", long_press, 1'b0);
    chk("relb_level", btn_level, 1'b1);
    cyc(1);
    chk("relb_long_pulse", long_press, 1'b1);
    btn = 1'b0;
    cyc(10);
    chk_int("relb_press_count", n_press_seen - p0, 0);

    // Reset mid-press while HELD.
    btn = 1'b1;
    cyc(10);
    chk("rstmid_level_before", btn_level, 1'b1);
    p0 = n_press_seen;
    @(posedge clk);
    #5 rst = 1'b1;
    #1;
    chk("rstmid_level", btn_level, 1'b0);
    chk("rstmid_press", press, 1'b0);
    chk("rstmid_long", long_press, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc(6);
    chk("rstmid_level_early", btn_level, 1'b0);
    cyc(1);
    chk("rstmid_level_rerise", btn_level, 1'b1);
    chk_int("rstmid_press_count", n_press_seen - p0, 0);
    btn = 1'b0;
    cyc(10);

    // Random traffic, with occasional one-cycle resets.
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
      btn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) cyc(int'($urandom_range(20, 30)));
      else                           cyc(int'($urandom_range(1, 7)));
    end
    btn = 1'b0;
    cyc(12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
